// File: rtl/logical_left_shift_seq_32bit_if.sv
// Start/done handshake and data bus for the sequential logical left shifter.
interface logical_left_shift_seq_32bit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] b;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;
  logic               lost;

  modport master (
    output start, a, b,
    input  busy, done, out, lost
  );

  modport slave (
    input  start, a, b,
    output busy, done, out, lost
  );
endinterface

// File: rtl/logical_left_shift_seq_32bit.sv
// Multi-cycle logical left shifter, one bit per clock, reporting shifted-out ones.
// Optional macro SHIFT_STRIDE4_EN: shift by four per clock while four or more remain.
module logical_left_shift_seq_32bit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic                      clk,
  input logic                      rst_n,
  logical_left_shift_seq_32bit_if.slave sif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_sh,    w_sh_nx;
  logic [SHAMT_W-1:0] r_cnt,   w_cnt_nx;
  logic               r_lz,    w_lz_nx;
  logic [WIDTH-1:0]   r_out,   w_out_nx;
  logic               r_lost,  w_lost_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_lz    <= 1'b0;
      r_out   <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sh    <= w_sh_nx;
      r_cnt   <= w_cnt_nx;
      r_lz    <= w_lz_nx;
      r_out   <= w_out_nx;
      r_lost  <= w_lost_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_sh_nx    = r_sh;
    w_cnt_nx   = r_cnt;
    w_lz_nx    = r_lz;
    w_out_nx   = r_out;
    w_lost_nx  = r_lost;
    unique case (r_state)
      IDLE, DONE: begin
        // DONE accepts a new request directly so back-to-back ops need no bubble
        if (sif.start) begin
          w_sh_nx    = sif.a;
          w_cnt_nx   = sif.b;
          w_lz_nx    = 1'b0;
          w_state_nx = SHIFT;
        end else if (r_state == DONE) begin
          w_state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == '0) begin
          w_out_nx   = r_sh;
          w_lost_nx  = r_lz;
          w_state_nx = DONE;
        end
`ifdef SHIFT_STRIDE4_EN
        else if (r_cnt >= SHAMT_W'(4)) begin
          w_sh_nx  = {r_sh[WIDTH-5:0], 4'b0000};
          w_lz_nx  = r_lz | (|r_sh[WIDTH-1:WIDTH-4]);
          w_cnt_nx = r_cnt - SHAMT_W'(4);
        end
`endif
        else begin
          w_sh_nx  = {r_sh[WIDTH-2:0], 1'b0};
          w_lz_nx  = r_lz | r_sh[WIDTH-1];
          w_cnt_nx = r_cnt - SHAMT_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign sif.busy = (r_state == SHIFT);
  assign sif.done = (r_state == DONE);
  assign sif.out  = r_out;
  assign sif.lost = r_lost;

endmodule

// File: tb/tb_logical_left_shift_seq_32bit.sv
// Directed table-driven bench for the sequential logical left shifter.
module tb_logical_left_shift_seq_32bit;

  logic clk;
  logic rst_n;

  logical_left_shift_seq_32bit_if #(.WIDTH(32), .SHAMT_W(5)) sif ();

  logical_left_shift_seq_32bit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] exp_out;
    logic        exp_lost;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_lat(input int unsigned sh);
`ifdef SHIFT_STRIDE4_EN
    return sh / 4 + sh % 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  // Accept one request, scramble inputs while busy, then check timing and result.
  task automatic run_op(input logic [31:0] a, input logic [4:0] b,
                        input logic [31:0] exp_out, input logic exp_lost);
    int unsigned edges;
    int unsigned busy_cnt;
    bit          got;
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.a     = $urandom;
    sif.b     = 5'($urandom);
    edges    = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && edges < 100) begin
      if (sif.busy) busy_cnt++;
      if (sif.busy && sif.done) check("busy_and_done", 32'd1, 32'd0);
      if (sif.done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", edges, exp_lat(b));
    check("busy_cycles", busy_cnt, exp_lat(b));
    check("out", sif.out, exp_out);
    check("lost", 32'(sif.lost), 32'(exp_lost));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(sif.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_done;
    int unsigned edges;
    bit          got;

    vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{32'hF000_0001, 5'd4,  32'h0000_0010, 1'b1};
    vecs[3] = '{32'h0FFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b0};
    vecs[4] = '{32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1};
    vecs[5] = '{32'h1234_5678, 5'd8,  32'h3456_7800, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'h0000_0003, 5'd30, 32'hC000_0000, 1'b0};
    vecs[8] = '{32'h0000_0007, 5'd30, 32'hC000_0000, 1'b1};
    vecs[9] = '{32'h0001_0000, 5'd16, 32'h0000_0000, 1'b1};

    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  sif.out, 32'h0);
    check("rst_lost", 32'(sif.lost), 32'd0);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_lost);

    // Start during busy: second request must be ignored
    sif.start = 1'b1;
    sif.a     = 32'h0000_0001;
    sif.b     = 5'd8;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    @(posedge clk);
    #1;
    sif.start = 1'b1;
    sif.a     = 32'hFFFF_FFFF;
    sif.b     = 5'd1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (sif.done) n_done++;
      @(posedge clk);
      #1;
    end
    check("busy_ign_pulses", n_done, 32'd1);
    check("busy_ign_out", sif.out, 32'h0000_0100);
    check("busy_ign_lost", 32'(sif.lost), 32'd0);

    // Asynchronous reset mid-shift
    sif.start = 1'b1;
    sif.a     = 32'h0000_0005;
    sif.b     = 5'd20;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(sif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(sif.busy), 32'd0);
    check("mid_rst_done", 32'(sif.done), 32'd0);
    check("mid_rst_out",  sif.out, 32'h0);
    check("mid_rst_lost", 32'(sif.lost), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (sif.done) n_done++;
    end
    check("post_rst_pulses", n_done, 32'd0);

    // Back-to-back: second start issued in the DONE cycle of the first
    sif.start = 1'b1;
    sif.a     = 32'h0000_0003;
    sif.b     = 5'd2;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 50) begin
      if (sif.done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_out", sif.out, 32'h0000_000C);
    sif.start = 1'b1;
    sif.a     = 32'h0000_0001;
    sif.b     = 5'd1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    check("b2b_no_bubble", 32'(sif.busy), 32'd1);
    check("b2b_out_held", sif.out, 32'h0000_000C);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 50) begin
      if (sif.done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_lat", edges, 32'd2);
    check("b2b_second_out", sif.out, 32'h0000_0002);
    check("b2b_second_lost", 32'(sif.lost), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
